// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Owns the single write port of the register file. Two writeback
//   requesters (A: ALU, B: load/external) share the port through a
//   round-robin valid/ready handshake. A clear sequence (init_req) zeroes
//   every register through the same port, one register per cycle.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   init_req            one-cycle request to clear all registers
//   init_busy           high while the clear sequence runs
//   a_valid/a_rd/a_data requester A write request; a_ready = accepted now
//   b_valid/b_rd/b_data requester B write request; b_ready = accepted now
//   rf_we/rf_rd/rf_wdata registered register-file write port
module regfile_write_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter bit DROP_X0 = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_req,
  output logic              init_busy,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata
);

  typedef enum logic {ST_ARB = 1'b0, ST_INIT = 1'b1} state_t;

  localparam logic              PRIO_A   = 1'b0;
  localparam logic              PRIO_B   = 1'b1;
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic                prio_q, prio_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_ARB;
    else       state_q <= state_d;
  end

  // Next-state logic: the clear counter tops out at the last register, so
  // leaving INIT happens on the same cycle the final address is issued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:  if (init_req)          state_d = ST_INIT;
      ST_INIT: if (cnt_q == CNT_LAST) state_d = ST_INIT == ST_INIT ? ST_ARB : ST_ARB;
      default:                        state_d = ST_ARB;
    endcase
  end

  // Outputs: init_req blocks both grants in its own cycle so the clear
  // sequence always wins over pending writes.
  always_comb begin
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    init_busy = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (!init_req) begin
          a_ready = a_valid && (!b_valid || prio_q == PRIO_A);
          b_ready = b_valid && (!a_valid || prio_q == PRIO_B);
        end
      end
      ST_INIT: init_busy = 1'b1;
      default: ;
    endcase
  end

  // Write-port datapath, priority pointer and clear counter. Address and
  // data hold their last values whenever no write is issued, including a
  // dropped write to x0.
  always_comb begin
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (state_q == ST_INIT) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = cnt_q;
      rf_wdata_d = '0;
      cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
    end else if (init_req) begin
      cnt_d = '0;
    end else if (a_ready) begin
      prio_d = PRIO_B;
      if (!(DROP_X0 && a_rd == '0)) begin
        rf_we_d    = 1'b1;
        rf_rd_d    = a_rd;
        rf_wdata_d = a_data;
      end
    end else if (b_ready) begin
      prio_d = PRIO_A;
      if (!(DROP_X0 && b_rd == '0)) begin
        rf_we_d    = 1'b1;
        rf_rd_d    = b_rd;
        rf_wdata_d = b_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q     <= PRIO_A;
      cnt_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: table of hand-computed vectors,
// hand-written clear/reset sequences, then randomized traffic checked
// against a behavioural model of the arbitration and clear rules.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_req;
  logic        init_busy;
  logic        a_valid, b_valid;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32), .DROP_X0(1'b1)) dut (
    .clk(clk), .reset(reset), .init_req(init_req), .init_busy(init_busy),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ireq, av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bd;
    logic        ear, ebr, ebusy, ewe;
    logic [4:0]  erd;
    logic [31:0] ewd;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drives one cycle of inputs, checks the
  // combinational handshake before the edge and the registered port after.
  task automatic apply(input string nm, input logic rst, input logic ireq,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic ear, input logic ebr, input logic ebusy,
                       input logic ewe, input logic [4:0] erd, input logic [31:0] ewd);
    reset = rst; init_req = ireq;
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    #1;
    chk({nm, ".a_ready"}, {31'd0, a_ready}, {31'd0, ear});
    chk({nm, ".b_ready"}, {31'd0, b_ready}, {31'd0, ebr});
    chk({nm, ".init_busy"}, {31'd0, init_busy}, {31'd0, ebusy});
    @(posedge clk);
    #1;
    chk({nm, ".rf_we"}, {31'd0, rf_we}, {31'd0, ewe});
    if (ewe) begin
      chk({nm, ".rf_rd"}, {27'd0, rf_rd}, {27'd0, erd});
      chk({nm, ".rf_wdata"}, rf_wdata, ewd);
    end else if (!rst) begin
      chk({nm, ".rf_rd_hold"}, {27'd0, rf_rd}, {27'd0, erd});
      chk({nm, ".rf_wdata_hold"}, rf_wdata, ewd);
    end else begin
      chk({nm, ".rf_rd_rst"}, {27'd0, rf_rd}, 32'd0);
      chk({nm, ".rf_wdata_rst"}, rf_wdata, 32'd0);
    end
  endtask

  // Behavioural model state
  bit          m_init;
  int          m_left;
  bit          m_prio_b;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  initial begin
    // Vectors: inputs then {a_ready, b_ready, init_busy, rf_we, rf_rd, rf_wdata}
    tbl[0] = '{1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 5'd1,  32'h100,      1'b1, 5'd11, 32'h200,  1'b1, 1'b0, 1'b0, 1'b1, 5'd1,  32'h100};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 5'd2,  32'h101,      1'b1, 5'd11, 32'h200,  1'b0, 1'b1, 1'b0, 1'b1, 5'd11, 32'h200};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 5'd2,  32'h101,      1'b1, 5'd12, 32'h201,  1'b1, 1'b0, 1'b0, 1'b1, 5'd2,  32'h101};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 5'd3,  32'h102,      1'b1, 5'd12, 32'h201,  1'b0, 1'b1, 1'b0, 1'b1, 5'd12, 32'h201};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 32'h201};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 5'd7,  32'h77,       1'b1, 5'd8,  32'h88,   1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  32'h77};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 5'd7,  32'h77};

    reset = 1'b1; init_req = 1'b0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset.rf_rd", {27'd0, rf_rd}, 32'd0);
    chk("reset.rf_wdata", rf_wdata, 32'd0);
    chk("reset.init_busy", {31'd0, init_busy}, 32'd0);

    for (int i = 0; i < 10; i++)
      apply($sformatf("vec%0d", i), tbl[i].rst, tbl[i].ireq, tbl[i].av, tbl[i].ard, tbl[i].ad,
            tbl[i].bv, tbl[i].brd, tbl[i].bd, tbl[i].ear, tbl[i].ebr, tbl[i].ebusy,
            tbl[i].ewe, tbl[i].erd, tbl[i].ewd);

    // Clear with A pending; a second init_req mid-sequence is ignored.
    apply("init_req", 1'b0, 1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0,
          1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h77);
    for (int k = 0; k < 32; k++)
      apply($sformatf("init%0d", k), 1'b0, (k == 5), 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0,
            1'b0, 1'b0, 1'b1, 1'b1, 5'(k), 32'h0);
    apply("post_init_a", 1'b0, 1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0,
          1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99);

    // Idle clear: no wrap-around write after the last register.
    apply("init2_req", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
          1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 32'h99);
    for (int k = 0; k < 32; k++)
      apply($sformatf("init2_%0d", k), 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
            1'b0, 1'b0, 1'b1, 1'b1, 5'(k), 32'h0);
    apply("no_wrap", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
          1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 32'h0);

    // Reset during the clear at cycle 10 aborts it and restores prio=A.
    apply("init3_req", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
          1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 32'h0);
    for (int k = 0; k < 10; k++)
      apply($sformatf("init3_%0d", k), 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
            1'b0, 1'b0, 1'b1, 1'b1, 5'(k), 32'h0);
    apply("init3_rst", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
          1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 3; k++)
      apply($sformatf("after_rst%0d", k), 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
            1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    apply("rst_prio_a", 1'b0, 1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66,
          1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h44);

    // Randomized traffic against the model. B is still pending (rd 6).
    m_init = 1'b0; m_left = 0; m_prio_b = 1'b1; m_we = 1'b1; m_rd = 5'd4; m_wd = 32'h44;
    begin
      logic        av, bv, rst, ireq, ga, gb, eb;
      logic [4:0]  ard, brd;
      logic [31:0] ad, bd;
      av = 1'b0; ard = '0; ad = '0;
      bv = 1'b1; brd = 5'd6; bd = 32'h66;
      for (int c = 0; c < 1500; c++) begin
        if (!av && $urandom_range(0, 1) == 1) begin
          av = 1'b1; ard = 5'($urandom_range(0, 31)); ad = $urandom;
        end
        if (!bv && $urandom_range(0, 1) == 1) begin
          bv = 1'b1; brd = 5'($urandom_range(0, 31)); bd = $urandom;
        end
        rst  = ($urandom_range(0, 299) == 0);
        ireq = ($urandom_range(0, 79) == 0);
        // Expected handshake from the arbitration rules
        eb = m_init;
        ga = 1'b0; gb = 1'b0;
        if (!m_init && !ireq) begin
          if (av && bv) begin ga = !m_prio_b; gb = m_prio_b; end
          else begin ga = av; gb = bv; end
        end
        // Expected register-file effect on the following edge
        if (rst) begin
          m_init = 1'b0; m_left = 0; m_prio_b = 1'b0; m_we = 1'b0; m_rd = '0; m_wd = '0;
        end else if (m_init) begin
          m_we = 1'b1; m_rd = 5'(32 - m_left); m_wd = '0;
          m_left--;
          if (m_left == 0) m_init = 1'b0;
        end else if (ireq) begin
          m_init = 1'b1; m_left = 32; m_we = 1'b0;
        end else if (ga || gb) begin
          m_prio_b = ga;
          if ((ga ? ard : brd) == 5'd0) m_we = 1'b0;
          else begin m_we = 1'b1; m_rd = ga ? ard : brd; m_wd = ga ? ad : bd; end
        end else begin
          m_we = 1'b0;
        end
        apply($sformatf("rnd%0d", c), rst, ireq, av, ard, ad, bv, brd, bd,
              ga, gb, eb, m_we, m_rd, m_wd);
        if (ga) av = 1'b0;
        if (gb) bv = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Controller that owns the single write port of the 32x32 register file. It shares the port between two writeback requesters (A: ALU writeback, B: load/external writeback) using round-robin arbitration over a valid/ready handshake. It also runs a clear sequence that zeroes every register through the normal write port. It sits between the execute/writeback stages and the register file's we/rd/indata inputs.

Parameters:
ADDR_W, 5, register address width; register count is 2**ADDR_W.
DATA_W, 32, write data width.
DROP_X0, 1, when 1, accepted writes to address 0 are consumed without asserting rf_we.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  reset, synchronous, active-high.
init_req  input  1  single-cycle request to clear all registers.
init_busy  output  1  high while the clear sequence runs.
a_valid  input  1  requester A has a write pending.
a_rd  input  ADDR_W  requester A destination register.
a_data  input  DATA_W  requester A write data.
a_ready  output  1  requester A write accepted this cycle.
b_valid  input  1  requester B has a write pending.
b_rd  input  ADDR_W  requester B destination register.
b_data  input  DATA_W  requester B write data.
b_ready  output  1  requester B write accepted this cycle.
rf_we  output  1  register file write enable (registered).
rf_rd  output  ADDR_W  register file write address (registered).
rf_wdata  output  DATA_W  register file write data (registered).

Behaviour:
- States: ARB, INIT. Reset value: state=ARB, prio=A, cnt=0, rf_we=0, rf_rd=0, rf_wdata=0, init_busy=0.
- Handshake: a transfer occurs when valid&&ready in the same cycle. Requesters hold rd/data stable until the transfer. ready is combinational from the valids, the state, prio and init_req.
- ARB grant rules:
  - Only one requester valid: that requester gets ready=1.
  - Both valid: the requester named by prio gets ready=1; the other gets ready=0.
  - Neither valid: both readies are 0 and prio is unchanged.
- prio update: after each grant, prio points to the requester that was not granted. A lone requester may therefore win on consecutive cycles.
- Latency: a transfer in cycle N drives rf_we=1, rf_rd=rd and rf_wdata=data in cycle N+1. At most one write per cycle. Full throughput is one write per cycle.
- No transfer in a cycle: rf_we=0 in the next cycle. rf_rd and rf_wdata hold their last values.
- DROP_X0=1 and granted rd==0: ready=1 and the handshake completes, but rf_we=0 in the next cycle. prio still updates.
- init_req=1 in ARB:
  - Both readies are 0 that cycle; init wins over any pending valid.
  - The block enters INIT next cycle with cnt=0.
- INIT:
  - init_busy=1 and both readies are 0.
  - Each cycle: rf_we=1, rf_rd=cnt, rf_wdata=0, registered as above. cnt increments.
  - The sequence issues exactly 2**ADDR_W writes (cnt 0..31), including x0 regardless of DROP_X0.
  - After issuing cnt=31, the block returns to ARB, cnt returns to 0 and init_busy falls.
  - The registered rf_we pulses span the 32 cycles after INIT entry.
- init_req while in INIT: ignored; the sequence does not restart.
- Pending valids during INIT are stalled, not lost. Arbitration resumes with the unchanged prio in the first ARB cycle.
- Reset asserted mid-INIT or mid-transfer: the sequence aborts. All state and outputs return to reset values on the next edge. No further rf_we pulses occur.
- cnt is ADDR_W+1 bits or a terminal compare on 2**ADDR_W-1. There is no wrap-around write to address 0 after 31.

Test Plan:
- A only: a_valid=1, a_rd=5, a_data=0xDEADBEEF -> a_ready=1 the same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; b_ready=0.
- Both requesters valid for 4 cycles after reset (A: rd=1..4, B: rd=11..14, held until accepted) -> grants alternate A,B,A,B; rf_rd sequence 1,11,2,12.
- Write to x0 with DROP_X0=1: b_valid=1, b_rd=0, b_data=0x1234 -> b_ready=1, rf_we stays 0 the next cycle; a following A/B contention grants A.
- init_req pulse with a_valid=1 held in the same cycle -> a_ready=0; init_busy=1 for 32 cycles; rf_we=1 with rf_rd stepping 0..31 and rf_wdata=0; a second init_req mid-sequence has no effect; A is granted in the first cycle after init_busy falls.
- Reset asserted at INIT cycle 10 -> next cycle rf_we=0, init_busy=0, state ARB, prio=A; no writes to addresses 10..31 follow.
